// File: rtl/pcm_pkg.sv
// Shared types and default parameter values for the PCM framer transmitter.
package pcm_pkg;

  // Framer sequencing states. IDLE is the only state where busy_o is low.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } pcm_state_e;

  localparam int unsigned PCM_WORD_W = 8;
  localparam int unsigned PCM_SYNC_W = 32;
  localparam int unsigned PCM_LEN_W  = 16;
  localparam int unsigned PCM_CNT_W  = 32;
  localparam int unsigned PCM_BAUD_W = 16;

endpackage

// File: rtl/pcm_baud_gen.sv
// Bit-clock divider: produces clk_o and a one-cycle launch tick that marks
// the clk_i cycle whose edge moves clk_o in the selected launch direction.
module pcm_baud_gen
  import pcm_pkg::*;
#(
  parameter int unsigned BAUD_W = PCM_BAUD_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              edge_i,
  input  logic [BAUD_W-1:0] baudrate_i,
  output logic              clk_o,
  output logic              tick_o
);

  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic [BAUD_W-1:0] limit;
  logic              clk_q, clk_d;
  logic              wrap;

  // Divider next-state: a baudrate of 0 behaves like 1; >= keeps a live
  // baudrate reduction from stranding the counter above the new limit.
  always_comb begin
    limit  = (baudrate_i == '0) ? BAUD_W'(1) : baudrate_i;
    wrap   = ((cnt_q + 1'b1) >= limit);
    cnt_d  = wrap ? '0 : (cnt_q + 1'b1);
    clk_d  = wrap ? ~clk_q : clk_q;
    // edge_i=0 launches on 0->1, edge_i=1 launches on 1->0
    tick_o = wrap & (clk_q == edge_i);
  end

  // Divider registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign clk_o = clk_q;

endmodule

// File: rtl/pcm_framer_tx.sv
// PCM frame transmitter: sync code, payload words and idle gap bits are
// serialised onto data_o, one bit per launch tick of the bit clock.
module pcm_framer_tx
  import pcm_pkg::*;
#(
  parameter int unsigned WORD_W = PCM_WORD_W,
  parameter int unsigned SYNC_W = PCM_SYNC_W,
  parameter int unsigned LEN_W  = PCM_LEN_W,
  parameter int unsigned CNT_W  = PCM_CNT_W
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic                         edge_i,
  input  logic                         msb_first_i,
  input  logic [15:0]                  baudrate_i,
  input  logic [LEN_W-1:0]             length_i,
  input  logic [SYNC_W-1:0]            code_i,
  input  logic [$clog2(SYNC_W+1)-1:0]  code_len_i,
  input  logic [CNT_W-1:0]             frame_cnt_i,
  input  logic [CNT_W-1:0]             gap_i,
  input  logic [WORD_W-1:0]            s_data_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  output logic                         data_o,
  output logic                         clk_o,
  output logic                         busy_o,
  output logic                         frame_done_o,
  output logic                         underrun_o
);

  localparam int unsigned CL_W  = $clog2(SYNC_W + 1);
  localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  pcm_state_e        state_q, state_d;
  logic              data_q, data_d;
  logic [CL_W-1:0]   sync_rem_q, sync_rem_d;
  logic [LEN_W-1:0]  word_q, word_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  gap_rem_q, gap_rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CL_W-1:0]   code_len_q, code_len_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  gap_q, gap_d;
  logic              msb_q, msb_d;
  logic [2:0]        start_sync_q, start_sync_d;
  logic              done_q, done_d;
  logic              under_q, under_d;

  logic              tick;
  logic              start_edge;
  logic              emitted;
  logic              take;
  logic              xfer;
  logic [CL_W-1:0]   sync_idx;
  logic [CL_W-1:0]   code_len_eff;
  logic [WORD_W-1:0] word_cur;
  logic [BIT_W-1:0]  bit_cur;
  logic [LEN_W-1:0]  word_idx;

  pcm_baud_gen #(.BAUD_W(16)) u_baud (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .edge_i     (edge_i),
    .baudrate_i (baudrate_i),
    .clk_o      (clk_o),
    .tick_o     (tick)
  );

  // State register: every flop of the framer, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      data_q       <= 1'b1;
      sync_rem_q   <= '0;
      word_q       <= '0;
      bit_q        <= '0;
      last_q       <= 1'b0;
      gap_rem_q    <= '0;
      cnt_q        <= '0;
      sh_q         <= '0;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      len_q        <= '0;
      code_len_q   <= '0;
      frame_cnt_q  <= '0;
      gap_q        <= '0;
      msb_q        <= 1'b0;
      start_sync_q <= '0;
      done_q       <= 1'b0;
      under_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      sync_rem_q   <= sync_rem_d;
      word_q       <= word_d;
      bit_q        <= bit_d;
      last_q       <= last_d;
      gap_rem_q    <= gap_rem_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      len_q        <= len_d;
      code_len_q   <= code_len_d;
      frame_cnt_q  <= frame_cnt_d;
      gap_q        <= gap_d;
      msb_q        <= msb_d;
      start_sync_q <= start_sync_d;
      done_q       <= done_d;
      under_q      <= under_d;
    end
  end

  // Next-state: on a launch tick the stages run in frame order (end of frame,
  // gap, sync, data) so a stage that finishes hands the same tick to the next
  // one and back-to-back bits stay contiguous.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    sync_rem_d   = sync_rem_q;
    word_d       = word_q;
    bit_d        = bit_q;
    last_d       = last_q;
    gap_rem_d    = gap_rem_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    len_d        = len_q;
    code_len_d   = code_len_q;
    frame_cnt_d  = frame_cnt_q;
    gap_d        = gap_q;
    msb_d        = msb_q;
    done_d       = 1'b0;
    under_d      = 1'b0;
    emitted      = 1'b0;
    take         = 1'b0;
    sync_idx     = '0;
    word_cur     = sh_q;
    bit_cur      = '0;
    word_idx     = '0;
    start_sync_d = {start_sync_q[1:0], start_i};
    start_edge   = start_sync_q[1] & ~start_sync_q[2];
    code_len_eff = (code_len_i > CL_W'(SYNC_W)) ? CL_W'(SYNC_W) : code_len_i;

    if (state_q == ST_IDLE) begin
      data_d = 1'b1;
      if (start_edge) begin
        state_d     = ST_SYNC;
        len_d       = length_i;
        code_len_d  = code_len_eff;
        frame_cnt_d = frame_cnt_i;
        gap_d       = gap_i;
        msb_d       = msb_first_i;
        cnt_d       = '0;
        sync_rem_d  = code_len_eff;
        word_d      = '0;
        bit_d       = '0;
        last_d      = 1'b0;
      end
    end else if (tick) begin
      // last payload bit period has just ended
      if (state_d == ST_DATA && last_q) begin
        done_d  = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        last_d  = 1'b0;
        data_d  = 1'b1;
        emitted = 1'b1;
        if (frame_cnt_q != '0 && cnt_d == frame_cnt_q) begin
          state_d = ST_IDLE;
        end else if (gap_q != '0) begin
          state_d   = ST_GAP;
          gap_rem_d = gap_q - 1'b1;
        end else begin
          state_d    = ST_SYNC;
          sync_rem_d = code_len_q;
          word_d     = '0;
          bit_d      = '0;
          emitted    = 1'b0;
        end
      end
      if (!emitted && state_d == ST_GAP) begin
        if (gap_rem_q != '0) begin
          data_d    = 1'b1;
          gap_rem_d = gap_rem_q - 1'b1;
          emitted   = 1'b1;
        end else begin
          state_d    = ST_SYNC;
          sync_rem_d = code_len_q;
          word_d     = '0;
          bit_d      = '0;
        end
      end
      if (!emitted && state_d == ST_SYNC) begin
        if (sync_rem_d != '0) begin
          sync_idx   = sync_rem_d - 1'b1;
          data_d     = |(code_i & (SYNC_W'(1) << sync_idx));
          sync_rem_d = sync_idx;
          emitted    = 1'b1;
          if (sync_idx == '0) begin
            state_d = ST_DATA;
            last_d  = (len_q == '0);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      if (!emitted && state_d == ST_DATA) begin
        if (len_q == '0) begin
          data_d = 1'b1;
          last_d = 1'b1;
        end else begin
          bit_cur  = bit_d;
          word_idx = word_d;
          if (bit_cur == '0) begin
            // first bit of a word: consume hold, or send zeros if it is empty
            take     = 1'b1;
            word_cur = hold_vld_q ? hold_q : '0;
            under_d  = ~hold_vld_q;
          end
          data_d = msb_q ? word_cur[WORD_W-1] : word_cur[0];
          sh_d   = msb_q ? (word_cur << 1) : (word_cur >> 1);
          if (bit_cur == BIT_W'(WORD_W - 1)) begin
            bit_d  = '0;
            word_d = word_idx + 1'b1;
            if (word_idx == len_q - 1'b1) last_d = 1'b1;
          end else begin
            bit_d = bit_cur + 1'b1;
          end
        end
      end
    end

    // Holding register. A word moves on a clk_i edge exactly when s_valid_i
    // and s_ready_o are both high; s_ready_o never depends on s_valid_i.
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (take) hold_vld_d = 1'b0;
    if (xfer) begin
      hold_d     = s_data_i;
      hold_vld_d = 1'b1;
    end

    // abort wins over everything: back to idle, line high, hold flushed
    if (abort_i) begin
      state_d    = ST_IDLE;
      data_d     = 1'b1;
      hold_vld_d = 1'b0;
      last_d     = 1'b0;
      done_d     = 1'b0;
      under_d    = 1'b0;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    busy_o       = (state_q != ST_IDLE);
    s_ready_o    = busy_o & ~hold_vld_q;
    xfer         = s_valid_i & s_ready_o;
    data_o       = data_q;
    frame_done_o = done_q;
    underrun_o   = under_q;
  end

endmodule

// File: tb/tb_pcm_framer_tx.sv
// Directed bench for pcm_framer_tx: bit stream, pulses and handshake checks.
module tb_pcm_framer_tx;

  localparam int WORD_W = 8;
  localparam int SYNC_W = 32;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 32;
  localparam int CL_W   = $clog2(SYNC_W + 1);

  logic              clk_i = 1'b0;
  logic              rst_n_i, start_i, abort_i, edge_i, msb_first_i;
  logic [15:0]       baudrate_i;
  logic [LEN_W-1:0]  length_i;
  logic [SYNC_W-1:0] code_i;
  logic [CL_W-1:0]   code_len_i;
  logic [CNT_W-1:0]  frame_cnt_i, gap_i;
  logic [WORD_W-1:0] s_data_i;
  logic              s_valid_i;
  logic              s_ready_o, data_o, clk_o, busy_o, frame_done_o, underrun_o;

  int checks   = 0;
  int failures = 0;

  logic [0:0]        cap_q[$];
  logic [0:0]        exp_q[$];
  int                done_pos_q[$];
  int                done_cnt  = 0;
  int                under_cnt = 0;
  logic [WORD_W-1:0] feed_q[$];
  bit                feed_en     = 1'b0;
  bit                edge_chk_en = 1'b0;
  logic              clk_prev  = 1'b0;
  logic              data_prev = 1'b1;
  logic              busy_prev = 1'b0;
  int                tog;

  pcm_framer_tx #(
    .WORD_W(WORD_W), .SYNC_W(SYNC_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .edge_i       (edge_i),
    .msb_first_i  (msb_first_i),
    .baudrate_i   (baudrate_i),
    .length_i     (length_i),
    .code_i       (code_i),
    .code_len_i   (code_len_i),
    .frame_cnt_i  (frame_cnt_i),
    .gap_i        (gap_i),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .data_o       (data_o),
    .clk_o        (clk_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .underrun_o   (underrun_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  // monitor: bits launched while busy, pulse counts, launch-edge discipline
  always @(negedge clk_i) begin
    if (clk_o !== clk_prev && clk_o === ~edge_i && busy_prev === 1'b1)
      cap_q.push_back(data_o);
    if (frame_done_o === 1'b1) begin
      done_cnt++;
      done_pos_q.push_back(cap_q.size());
    end
    if (underrun_o === 1'b1) under_cnt++;
    if (edge_chk_en && data_o !== data_prev) begin
      checks++;
      assert (clk_o !== clk_prev && clk_o === ~edge_i) else begin
        failures++;
        $error("FAIL launch_edge: data_o changed with clk_o %b->%b, required change only as clk_o goes to %b",
               clk_prev, clk_o, ~edge_i);
      end
    end
    clk_prev  = clk_o;
    data_prev = data_o;
    busy_prev = busy_o;
  end

  // driver: presents feed_q words on s_data_i, pops after each accepted transfer
  initial begin : feeder
    bit xfer_pend;
    logic [WORD_W-1:0] dummy;
    xfer_pend = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    forever begin
      @(negedge clk_i);
      if (xfer_pend && feed_q.size() > 0) dummy = feed_q.pop_front();
      s_valid_i = feed_en && (feed_q.size() > 0);
      s_data_i  = (feed_q.size() > 0) ? feed_q[0] : '0;
      xfer_pend = s_valid_i && s_ready_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic push_bits(input logic [31:0] v, input int n, input bit msb);
    for (int i = 0; i < n; i++) exp_q.push_back(msb ? v[n-1-i] : v[i]);
  endtask

  task automatic clear_run();
    cap_q.delete();
    exp_q.delete();
    done_pos_q.delete();
    done_cnt  = 0;
    under_cnt = 0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    cycles(4);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy_o === 1'b1 && n < budget) begin
      cycles(1);
      n++;
    end
    chk({tag, "_idle_timeout"}, {31'd0, busy_o}, 32'd0);
    cycles(4);
  endtask

  task automatic wait_bits(input string tag, input int nbits);
    int n;
    n = 0;
    while (cap_q.size() < nbits && n < 2000) begin
      cycles(1);
      n++;
    end
    chk({tag, "_bits_timeout"}, {31'd0, (cap_q.size() >= nbits)}, 32'd1);
  endtask

  task automatic check_stream(input string tag);
    checks++;
    assert (cap_q.size() === exp_q.size()) else begin
      failures++;
      $error("FAIL %s_len: got %0d bits required %0d", tag, cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      assert (cap_q[i] === exp_q[i]) else begin
        failures++;
        $error("FAIL %s_bit%0d: got %b required %b", tag, i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic count_toggles(input int n, output int t);
    logic p;
    t = 0;
    p = clk_o;
    repeat (n) begin
      cycles(1);
      if (clk_o !== p) t++;
      p = clk_o;
    end
  endtask

  function automatic int first_done();
    return (done_pos_q.size() > 0) ? done_pos_q[0] : -1;
  endfunction

  // directed sequence
  initial begin
    rst_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; edge_i = 1'b0; msb_first_i = 1'b1;
    baudrate_i = 16'd2; length_i = 16'd2; code_i = 32'hEB90; code_len_i = CL_W'(16);
    frame_cnt_i = 32'd1; gap_i = 32'd0;

    // reset values
    cycles(3);
    chk("rst_data", {31'd0, data_o}, 32'd1);
    chk("rst_clk", {31'd0, clk_o}, 32'd0);
    chk("rst_ready", {31'd0, s_ready_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, frame_done_o}, 32'd0);
    chk("rst_under", {31'd0, underrun_o}, 32'd0);
    rst_n_i = 1'b1;
    cycles(2);
    edge_chk_en = 1'b1;

    // clk_o keeps running in idle: baud 2 -> one toggle every 2 cycles
    count_toggles(20, tog);
    chk("idle_toggles_b2", tog, 32'd10);
    chk("idle_data", {31'd0, data_o}, 32'd1);

    // EB90 A5 3C, MSB first, single frame
    clear_run();
    feed_q.push_back(8'hA5); feed_q.push_back(8'h3C); feed_en = 1'b1;
    do_start();
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    wait_idle("t1", 3000);
    push_bits(32'hEB90, 16, 1'b1); push_bits(32'hA5, 8, 1'b1); push_bits(32'h3C, 8, 1'b1);
    exp_q.push_back(1'b1);
    check_stream("t1");
    chk("t1_done_cnt", done_cnt, 32'd1);
    chk("t1_done_pos", first_done(), 32'd33);
    chk("t1_under", under_cnt, 32'd0);
    chk("t1_ready_idle", {31'd0, s_ready_o}, 32'd0);

    // same frame LSB-first payload (sync stays MSB first)
    clear_run();
    msb_first_i = 1'b0;
    feed_q.push_back(8'hA5); feed_q.push_back(8'h3C);
    do_start();
    wait_idle("t2", 3000);
    push_bits(32'hEB90, 16, 1'b1); push_bits(32'hA5, 8, 1'b0); push_bits(32'h3C, 8, 1'b0);
    exp_q.push_back(1'b1);
    check_stream("t2");
    chk("t2_done_cnt", done_cnt, 32'd1);

    // three frames with a 5-bit gap; a start edge while busy is ignored
    clear_run();
    msb_first_i = 1'b1; frame_cnt_i = 32'd3; gap_i = 32'd5;
    feed_q.push_back(8'hA5); feed_q.push_back(8'h3C); feed_q.push_back(8'h12);
    feed_q.push_back(8'h34); feed_q.push_back(8'h56); feed_q.push_back(8'h78);
    do_start();
    wait_bits("t3", 10);
    do_start();
    wait_idle("t3", 5000);
    push_bits(32'hEB90, 16, 1'b1); push_bits(32'hA53C, 16, 1'b1); push_bits(32'h1F, 5, 1'b1);
    push_bits(32'hEB90, 16, 1'b1); push_bits(32'h1234, 16, 1'b1); push_bits(32'h1F, 5, 1'b1);
    push_bits(32'hEB90, 16, 1'b1); push_bits(32'h5678, 16, 1'b1);
    exp_q.push_back(1'b1);
    check_stream("t3");
    chk("t3_done_cnt", done_cnt, 32'd3);
    chk("t3_done_pos0", first_done(), 32'd33);
    chk("t3_done_pos1", (done_pos_q.size() > 1) ? done_pos_q[1] : -1, 32'd70);
    chk("t3_done_pos2", (done_pos_q.size() > 2) ? done_pos_q[2] : -1, 32'd107);

    // underrun: only the first word is supplied
    clear_run();
    frame_cnt_i = 32'd1; gap_i = 32'd0;
    feed_q.push_back(8'hA5);
    do_start();
    wait_idle("t4", 3000);
    push_bits(32'hEB90, 16, 1'b1); push_bits(32'hA5, 8, 1'b1); push_bits(32'h00, 8, 1'b1);
    exp_q.push_back(1'b1);
    check_stream("t4");
    chk("t4_under", under_cnt, 32'd1);
    chk("t4_done_cnt", done_cnt, 32'd1);

    // abort during word 1, then a clean frame with new words
    clear_run();
    feed_q.push_back(8'hA5); feed_q.push_back(8'h3C);
    do_start();
    wait_bits("t5", 18);
    edge_chk_en = 1'b0; feed_en = 1'b0; abort_i = 1'b1;
    cycles(1);
    abort_i = 1'b0;
    chk("t5_abort_busy", {31'd0, busy_o}, 32'd0);
    chk("t5_abort_data", {31'd0, data_o}, 32'd1);
    chk("t5_abort_ready", {31'd0, s_ready_o}, 32'd0);
    cycles(20);
    chk("t5_abort_no_done", done_cnt, 32'd0);
    chk("t5_abort_idle", {31'd0, busy_o}, 32'd0);
    feed_q.delete();
    edge_chk_en = 1'b1;
    clear_run();
    feed_q.push_back(8'h5A); feed_q.push_back(8'hC3); feed_en = 1'b1;
    do_start();
    wait_idle("t5b", 3000);
    push_bits(32'hEB90, 16, 1'b1); push_bits(32'h5A, 8, 1'b1); push_bits(32'hC3, 8, 1'b1);
    exp_q.push_back(1'b1);
    check_stream("t5b");
    chk("t5b_done_cnt", done_cnt, 32'd1);

    // falling-edge launch, baud 1, no sync, one word
    clear_run();
    edge_i = 1'b1; baudrate_i = 16'd1; code_len_i = '0; length_i = 16'd1;
    cycles(4);
    count_toggles(20, tog);
    chk("idle_toggles_b1", tog, 32'd20);
    feed_q.push_back(8'h96);
    do_start();
    wait_idle("t6", 3000);
    push_bits(32'h96, 8, 1'b1);
    exp_q.push_back(1'b1);
    check_stream("t6");
    chk("t6_done_pos", first_done(), 32'd9);

    // reset mid-frame abandons the frame with no pulses
    clear_run();
    edge_i = 1'b0; baudrate_i = 16'd2; code_len_i = CL_W'(16); length_i = 16'd2;
    feed_q.push_back(8'hA5); feed_q.push_back(8'h3C);
    do_start();
    wait_bits("t7", 5);
    edge_chk_en = 1'b0; feed_en = 1'b0; rst_n_i = 1'b0;
    cycles(2);
    chk("t7_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("t7_rst_data", {31'd0, data_o}, 32'd1);
    chk("t7_rst_clk", {31'd0, clk_o}, 32'd0);
    chk("t7_rst_ready", {31'd0, s_ready_o}, 32'd0);
    rst_n_i = 1'b1;
    cycles(20);
    chk("t7_no_done", done_cnt, 32'd0);
    chk("t7_no_under", under_cnt, 32'd0);
    feed_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
